fp_addsub_pipe: RTL and testbench
=================================

# fp_addsub_pipe

Parametrised pipelined IEEE-754-style floating-point adder/subtractor. It succeeds the fixed 32-bit adder with configurable exponent and mantissa widths, a per-operation add/sub select, round-to-nearest-even, valid tracking, a pipeline-advance enable and exception flags. It sits in the arithmetic datapath next to the pipelined multiplier and accepts one operation per enabled cycle.

## Interface
- EXP_W, 8, exponent width (≥3); bias = 2^(EXP_W-1)-1
- MAN_W, 23, stored fraction width (≥2); W = 1+EXP_W+MAN_W
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  pipeline advance; when 0 every stage register, including out_valid, holds its value
- in_valid  in  1  A/B/sub are a real operation this cycle
- sub  in  1  0: A+B, 1: A−B (B sign inverted at S1)
- A  in  W  operand {sign, exp, frac}
- B  in  W  operand
- F  out  W  result
- out_valid  out  1  F and flags correspond to an issued operation
- flags  out  4  {invalid, overflow, underflow, inexact} for the current F

## Operation
- S1 unpack: classify zero/subnormal/normal/inf/NaN; subnormal inputs are treated as signed zero (flush-to-zero). Apply sub. Swap so the larger magnitude is operand X (compare exp, then frac).
- S2 align: right-shift the smaller significand (hidden bit included) by the exponent difference into MAN_W+3 bits (guard, round, sticky). Sticky is the OR of all bits shifted out. A difference > MAN_W+2 leaves sticky only.
- S3 add/sub: add when signs match, otherwise X−Y; the result carries one extra carry bit. Result sign = X sign.
- S4 normalise/round/pack: carry → shift right 1 (sticky absorbs the lost bit), exp+1; otherwise left-shift by leading-zero count, exp−lzc. Round to nearest, ties to even; a rounding carry renormalises.
- Specials, priority order:
  - any NaN, or inf−inf → canonical qNaN {0, all-ones, 1 then zeros}, invalid=1
  - single inf → that inf
  - exact cancellation → +0, except (−0)+(−0) → −0
  - exp ≥ all-ones after rounding → signed inf, overflow=1, inexact=1
  - exp ≤ 0 → signed zero, underflow=1, inexact=1
- inexact=1 whenever any guard, round or sticky bit is nonzero before rounding.
- Operations with in_valid=0 still flow through the pipeline. Their F and flags are don't-care, and out_valid=0 for them.

## Timing
- Latency 4 enabled edges: an operation sampled at enabled edge n appears on F/flags with out_valid=1 after enabled edge n+4.
- Throughput 1 op per enabled cycle; no backpressure other than en.
- en=0: all stages frozen. A result held at the output keeps out_valid=1 for the whole stall. The inputs present during a stall are ignored.
- Reset: F=0, flags=0, out_valid=0. All internal valid bits are cleared, so in-flight operations are discarded. rst has priority over en. The first post-reset result can appear no earlier than 4 enabled edges after rst is released.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Defaults, back-to-back, en=1: 3F800000+3F800000 → 40000000; 40400000 sub 3F800000 → 40000000; 3F800000 sub 3F800000 → 00000000. out_valid=1 on edges 4, 5, 6; flags=0.
- Rounding: 3F800000+33800000 (tie) → 3F800000 with inexact; 3F800000+34400000 → 3F800002 with inexact; 00400000 (subnormal)+3F800000 → 3F800000, flags=0.
- Specials: 7F800000+FF800000 → 7FC00000, invalid; 7F7FFFFF+7F7FFFFF → 7F800000, overflow+inexact; 80000000+80000000 → 80000000; 7FC00001+3F800000 → 7FC00000, invalid.
- Stall: issue 3 ops, hold en=0 for 5 cycles mid-stream → no results lost or duplicated, the out_valid count is 3, order is preserved, and the output stays stable during the stall.
- Reset mid-flight: issue 3 ops, assert rst for 1 cycle after the 2nd edge → F=0, flags=0, out_valid=0; no stale result appears afterwards.
- EXP_W=5, MAN_W=10: 3C00+3C00 → 4000; 7BFF+7BFF → 7C00 with overflow; 3C00 sub 3C00 → 0000.

Source files
------------

// File: rtl/fp_addsub_if.sv
// Operand/result bundle for the pipelined floating-point adder/subtractor.
// Widths follow the exponent/fraction parameters of the attached datapath.
interface fp_addsub_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic         en;
    logic         in_valid;
    logic         sub;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [W-1:0] F;
    logic         out_valid;
    logic [3:0]   flags;

    modport master (output en, in_valid, sub, A, B, input F, out_valid, flags);
    modport slave  (input en, in_valid, sub, A, B, output F, out_valid, flags);
endinterface

// File: rtl/fp_addsub_pipe.sv
// Pipelined floating-point add/sub with flush-to-zero inputs, round-to-nearest-even
// and exception flags; input register plus four logic stages, advanced by en.
module fp_addsub_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input logic        clk,
    input logic        rst,
    fp_addsub_if.slave bus
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int SH = MAN_W + 3;
    localparam int SW = MAN_W + 4;
    localparam int LW = $clog2(SW + 1);
    localparam int EW = EXP_W + LW + 2;
    localparam logic [EXP_W-1:0]        EMAX   = '1;
    localparam logic signed [EW-1:0]    EMAX_S = $signed({{(EW-EXP_W){1'b0}}, EMAX});
    localparam logic signed [EW-1:0]    EZERO  = '0;

    function automatic logic [LW-1:0] lzc(input logic [SW-1:0] v);
        logic [LW-1:0] n;
        n = LW'(SW);
        for (int i = 0; i < SW; i++)
            if (v[i]) n = LW'(SW - 1 - i);
        return n;
    endfunction

    function automatic logic rne_up(input logic lsb, input logic g, input logic r, input logic s);
        return g & (r | s | lsb);
    endfunction

    logic [W-1:0]       a_p0, b_p0;
    logic               sub_p0, vld_p0;
    logic               sx_p1, sy_p1, nan_p1, inf_p1, infs_p1, vld_p1;
    logic [EXP_W-1:0]   ex_p1, d_p1;
    logic [MAN_W:0]     mx_p1, my_p1;
    logic               sx_p2, sy_p2, nan_p2, inf_p2, infs_p2, vld_p2;
    logic [EXP_W-1:0]   ex_p2;
    logic [SW-1:0]      xs_p2, ys_p2;
    logic               sx_p3, zs_p3, nan_p3, inf_p3, infs_p3, vld_p3;
    logic [EXP_W-1:0]   ex_p3;
    logic [SW:0]        sum_p3;

    // S1: unpack, flush subnormals, apply sub, order by magnitude
    logic             sa, sb, a_nz, b_nz, a_sp, b_sp, a_nan, b_nan, a_inf, b_inf, swap;
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] fa, fb;
    always_comb begin
        sa    = a_p0[W-1];
        sb    = b_p0[W-1] ^ sub_p0;
        ea    = a_p0[W-2:MAN_W];
        eb    = b_p0[W-2:MAN_W];
        a_nz  = |ea;
        b_nz  = |eb;
        a_sp  = &ea;
        b_sp  = &eb;
        fa    = a_nz ? a_p0[MAN_W-1:0] : '0;
        fb    = b_nz ? b_p0[MAN_W-1:0] : '0;
        a_nan = a_sp & (|fa);
        b_nan = b_sp & (|fb);
        a_inf = a_sp & ~(|fa);
        b_inf = b_sp & ~(|fb);
        swap  = {eb, fb} > {ea, fa};
    end

    // S2: align the smaller significand, folding shifted-out bits into sticky
    logic [31:0]     dsh;
    logic [2*SH-1:0] wide;
    logic [SW-1:0]   ys_al;
    always_comb begin
        dsh   = (32'(d_p1) > 32'(SH)) ? 32'(SH) : 32'(d_p1);
        wide  = {my_p1, 2'b00, {SH{1'b0}}} >> dsh;
        ys_al = {wide[2*SH-1:SH], |wide[SH-1:0]};
    end

    // S4: normalise, round, detect specials, pack
    logic                    carry, inex;
    logic [LW-1:0]           lz;
    logic [SW-1:0]           norm;
    logic signed [EW-1:0]    e_n, e_r;
    logic [MAN_W+1:0]        mant;
    logic [MAN_W-1:0]        frac;
    logic [W-1:0]            f_s4;
    logic [3:0]              fl_s4;
    always_comb begin
        carry = sum_p3[SW];
        lz    = lzc(sum_p3[SW-1:0]);
        if (carry) begin
            norm = {sum_p3[SW:2], sum_p3[1] | sum_p3[0]};
            e_n  = $signed({{(EW-EXP_W){1'b0}}, ex_p3}) + EW'(1);
        end else begin
            norm = sum_p3[SW-1:0] << lz;
            e_n  = $signed({{(EW-EXP_W){1'b0}}, ex_p3}) - $signed({{(EW-LW){1'b0}}, lz});
        end
        inex  = |norm[2:0];
        mant  = {1'b0, norm[SW-1:3]} + (MAN_W+2)'(rne_up(norm[3], norm[2], norm[1], norm[0]));
        e_r   = mant[MAN_W+1] ? e_n + EW'(1) : e_n;
        frac  = mant[MAN_W+1] ? mant[MAN_W:1] : mant[MAN_W-1:0];
        f_s4  = {sx_p3, e_r[EXP_W-1:0], frac};
        fl_s4 = {3'b000, inex};
        if (nan_p3) begin
            f_s4  = {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};
            fl_s4 = 4'b1000;
        end else if (inf_p3) begin
            f_s4  = {infs_p3, EMAX, {MAN_W{1'b0}}};
            fl_s4 = 4'b0000;
        end else if (sum_p3 == '0) begin
            f_s4  = {zs_p3, {(W-1){1'b0}}};
            fl_s4 = 4'b0000;
        end else if (e_r >= EMAX_S) begin
            f_s4  = {sx_p3, EMAX, {MAN_W{1'b0}}};
            fl_s4 = 4'b0101;
        end else if (e_r <= EZERO) begin
            f_s4  = {sx_p3, {(W-1){1'b0}}};
            fl_s4 = 4'b0011;
        end
    end

    always_ff @(posedge clk) begin
        if (bus.en) begin
            a_p0    <= bus.A;
            b_p0    <= bus.B;
            sub_p0  <= bus.sub;

            sx_p1   <= swap ? sb : sa;
            sy_p1   <= swap ? sa : sb;
            ex_p1   <= swap ? eb : ea;
            d_p1    <= swap ? eb - ea : ea - eb;
            mx_p1   <= swap ? {b_nz, fb} : {a_nz, fa};
            my_p1   <= swap ? {a_nz, fa} : {b_nz, fb};
            nan_p1  <= a_nan | b_nan | (a_inf & b_inf & (sa != sb));
            inf_p1  <= a_inf | b_inf;
            infs_p1 <= a_inf ? sa : sb;

            sx_p2   <= sx_p1;
            sy_p2   <= sy_p1;
            ex_p2   <= ex_p1;
            xs_p2   <= {mx_p1, 3'b000};
            ys_p2   <= ys_al;
            nan_p2  <= nan_p1;
            inf_p2  <= inf_p1;
            infs_p2 <= infs_p1;

            // S3: magnitude add or subtract, X is never smaller than Y
            sx_p3   <= sx_p2;
            zs_p3   <= sx_p2 & sy_p2;
            ex_p3   <= ex_p2;
            sum_p3  <= (sx_p2 == sy_p2) ? ({1'b0, xs_p2} + {1'b0, ys_p2})
                                        : ({1'b0, xs_p2} - {1'b0, ys_p2});
            nan_p3  <= nan_p2;
            inf_p3  <= inf_p2;
            infs_p3 <= infs_p2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0        <= 1'b0;
            vld_p1        <= 1'b0;
            vld_p2        <= 1'b0;
            vld_p3        <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.F         <= '0;
            bus.flags     <= '0;
        end else if (bus.en) begin
            vld_p0        <= bus.in_valid;
            vld_p1        <= vld_p0;
            vld_p2        <= vld_p1;
            vld_p3        <= vld_p2;
            bus.out_valid <= vld_p3;
            bus.F         <= f_s4;
            bus.flags     <= fl_s4;
        end
    end
endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Scoreboard bench for fp_addsub_pipe: single-precision and half-precision instances
// driven with directed vectors; monitors pop expected results as outputs appear.
module tb_fp_addsub_pipe;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fp_addsub_if #(.EXP_W(8), .MAN_W(23)) bs ();
    fp_addsub_if #(.EXP_W(5), .MAN_W(10)) bh ();

    fp_addsub_pipe #(.EXP_W(8), .MAN_W(23)) dut_s (.clk(clk), .rst(rst), .bus(bs));
    fp_addsub_pipe #(.EXP_W(5), .MAN_W(10)) dut_h (.clk(clk), .rst(rst), .bus(bh));

    typedef struct {
        logic [31:0] f;
        logic [3:0]  fl;
        int          tgt;
        int          id;
    } exp_t;

    exp_t qs[$];
    exp_t qh[$];
    int checks = 0, errors = 0;
    int cnt_s = 0, cnt_h = 0;
    int recv_s = 0, recv_h = 0, sent_s = 0, sent_h = 0;
    int next_id = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Monitor for the single-precision instance
    initial forever begin
        logic e, r;
        exp_t x;
        @(posedge clk);
        e = bs.en;
        r = rst;
        if (e) cnt_s++;
        @(negedge clk);
        if (!r && e && bs.out_valid === 1'b1) begin
            recv_s++;
            if (qs.size() == 0) begin
                check("s_unexpected_result", {28'h0, bs.F, bs.flags}, 64'hDEAD);
            end else begin
                x = qs.pop_front();
                check($sformatf("s_op%0d_result", x.id), {28'h0, bs.F, bs.flags}, {28'h0, x.f, x.fl});
                check($sformatf("s_op%0d_latency", x.id), 64'(cnt_s), 64'(x.tgt));
            end
        end
    end

    // Monitor for the half-precision instance
    initial forever begin
        logic e, r;
        exp_t x;
        @(posedge clk);
        e = bh.en;
        r = rst;
        if (e) cnt_h++;
        @(negedge clk);
        if (!r && e && bh.out_valid === 1'b1) begin
            recv_h++;
            if (qh.size() == 0) begin
                check("h_unexpected_result", {44'h0, bh.F, bh.flags}, 64'hDEAD);
            end else begin
                x = qh.pop_front();
                check($sformatf("h_op%0d_result", x.id), {44'h0, bh.F, bh.flags}, {28'h0, x.f, x.fl});
                check($sformatf("h_op%0d_latency", x.id), 64'(cnt_h), 64'(x.tgt));
            end
        end
    end

    task automatic issue_s(input logic [31:0] a, input logic [31:0] b, input logic s,
                           input logic [31:0] f, input logic [3:0] fl);
        exp_t x;
        bs.A = a;
        bs.B = b;
        bs.sub = s;
        bs.in_valid = 1'b1;
        x.f = f;
        x.fl = fl;
        x.tgt = cnt_s + 5;
        x.id = next_id;
        next_id++;
        sent_s++;
        qs.push_back(x);
        @(negedge clk);
        bs.in_valid = 1'b0;
    endtask

    task automatic issue_h(input logic [15:0] a, input logic [15:0] b, input logic s,
                           input logic [15:0] f, input logic [3:0] fl);
        exp_t x;
        bh.A = a;
        bh.B = b;
        bh.sub = s;
        bh.in_valid = 1'b1;
        x.f = {16'h0, f};
        x.fl = fl;
        x.tgt = cnt_h + 5;
        x.id = next_id;
        next_id++;
        sent_h++;
        qh.push_back(x);
        @(negedge clk);
        bh.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bs.in_valid = 1'b0;
        bh.in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        bs.en = 1'b1; bs.in_valid = 1'b0; bs.sub = 1'b0; bs.A = '0; bs.B = '0;
        bh.en = 1'b1; bh.in_valid = 1'b0; bh.sub = 1'b0; bh.A = '0; bh.B = '0;
        repeat (3) @(negedge clk);
        check("reset_s_outputs", {27'h0, bs.out_valid, bs.F, bs.flags}, 64'h0);
        check("reset_h_outputs", {43'h0, bh.out_valid, bh.F, bh.flags}, 64'h0);
        rst = 1'b0;

        // Back-to-back basic arithmetic
        issue_s(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'h0);
        issue_s(32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 4'h0);
        issue_s(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'h0);
        issue_s(32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 4'h0);
        issue_s(32'h40000000, 32'hC0000000, 1'b0, 32'h00000000, 4'h0);
        // Rounding and flush-to-zero
        issue_s(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'h1);
        issue_s(32'h3F800000, 32'h34400000, 1'b0, 32'h3F800002, 4'h1);
        issue_s(32'h00400000, 32'h3F800000, 1'b0, 32'h3F800000, 4'h0);
        // Specials
        issue_s(32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 4'h8);
        issue_s(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'h5);
        issue_s(32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'h0);
        issue_s(32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'h8);
        issue_s(32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 4'h0);
        issue_s(32'h00800000, 32'h00C00000, 1'b1, 32'h80000000, 4'h3);
        idle(6);

        // Stall with the first of three results held at the output
        issue_s(32'h40000000, 32'h40000000, 1'b0, 32'h40800000, 4'h0);
        issue_s(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'h0);
        issue_s(32'h40A00000, 32'h3F800000, 1'b1, 32'h40800000, 4'h0);
        idle(2);
        bs.en = 1'b0;
        bs.in_valid = 1'b1;
        bs.A = 32'h7F800001;
        bs.B = 32'hFF800000;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("stall_hold_%0d", i), {27'h0, bs.out_valid, bs.F, bs.flags},
                  {27'h0, 1'b1, 32'h40800000, 4'h0});
        end
        bs.in_valid = 1'b0;
        bs.en = 1'b1;
        idle(8);

        // Reset while operations are in flight
        bs.A = 32'h3F800000; bs.B = 32'h3F800000; bs.sub = 1'b0; bs.in_valid = 1'b1;
        @(negedge clk);
        bs.A = 32'h40400000;
        @(negedge clk);
        bs.A = 32'h40800000;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bs.in_valid = 1'b0;
        check("midflight_reset_outputs", {27'h0, bs.out_valid, bs.F, bs.flags}, 64'h0);
        idle(8);
        issue_s(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'h0);
        idle(6);

        // Half-precision instance
        issue_h(16'h3C00, 16'h3C00, 1'b0, 16'h4000, 4'h0);
        issue_h(16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 4'h5);
        issue_h(16'h3C00, 16'h3C00, 1'b1, 16'h0000, 4'h0);
        issue_h(16'h3C00, 16'h1400, 1'b0, 16'h3C01, 4'h0);
        idle(10);

        check("s_results_received", 64'(recv_s), 64'(sent_s));
        check("h_results_received", 64'(recv_h), 64'(sent_h));
        check("s_queue_drained", 64'(qs.size()), 64'h0);
        check("h_queue_drained", 64'(qh.size()), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
